// File: rtl/layer4_pkg.sv
// Shared definitions for the layer-4 pooled-map buffer.
package layer4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } l4_state_e;

    localparam int L4_NUM_PIX = 144;
    localparam int L4_ADDR_W  = 8;

    // Final ReLU: with signed input a set MSB (negative sample) stores as 0.
    // Width is passed in so one function serves any DATA_W up to 32.
    function automatic logic [31:0] relu_clamp(input logic [31:0] d,
                                               input int unsigned w,
                                               input logic signed_in);
        if (signed_in && d[w-1])
            return 32'd0;
        return d;
    endfunction

endpackage

// File: rtl/layer_4_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A same-address read and write returns the old word.
module layer_4_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 144,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write and registered read in one block; non-blocking read gives old data on collision.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/layer_4_pool_buffer.sv
// Captures the 12x12 pooled map from layer 3, applies a final ReLU and
// serves random-access reads to the next layer once the map is complete.
module layer_4_pool_buffer
    import layer4_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_PIX   = L4_NUM_PIX,
    parameter int ADDR_W    = L4_ADDR_W,
    parameter int SIGNED_IN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_4_begin,
    input  logic [DATA_W-1:0] pool_d_in,
    input  logic              pool_valid,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              layer_4_ready,
    output logic              layer_4_write_complete,
    output logic              overflow_err,
    output logic [ADDR_W-1:0] wr_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);
    localparam logic [ADDR_W-1:0] FULL_CNT = ADDR_W'(NUM_PIX);

    l4_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_count_q, wr_count_d;
    logic              pool_valid_q;
    logic              complete_q, complete_d;
    logic              ovf_q, ovf_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_zero_q, rd_zero_d;

    logic              cap;
    logic              we;
    logic              rd_in_range;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] ram_rdata;

    // A held pool_valid only captures on its rising edge.
    assign cap         = pool_valid & ~pool_valid_q;
    assign rd_in_range = (rd_addr < FULL_CNT);
    assign wr_data     = DATA_W'(relu_clamp(32'(pool_d_in), DATA_W, SIGNED_IN != 0));

    // Fill sequencing: arm, count captures, flag completion and overflow.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        complete_d = 1'b0;
        ovf_d      = ovf_q;
        we         = 1'b0;
        if (layer_4_begin)
            ovf_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (layer_4_begin) begin
                    state_d    = FILL;
                    wr_count_d = '0;
                end
            end
            FILL: begin
                // Restart wins over a same-cycle capture.
                if (layer_4_begin) begin
                    wr_count_d = '0;
                end else if (cap) begin
                    we = 1'b1;
                    if (wr_count_q == LAST_IDX) begin
                        wr_count_d = FULL_CNT;
                        state_d    = FULL;
                        complete_d = 1'b1;
                    end else begin
                        wr_count_d = wr_count_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (layer_4_begin) begin
                    state_d    = FILL;
                    wr_count_d = '0;
                end else if (cap) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                wr_count_d = '0;
            end
        endcase
    end

    // Read qualification: out-of-range reads force zero data; valid only from FULL.
    always_comb begin
        rd_valid_d = 1'b0;
        rd_zero_d  = rd_zero_q;
        if (rd_en) begin
            rd_valid_d = rd_in_range && (state_q == FULL);
            rd_zero_d  = ~rd_in_range;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_count_q   <= '0;
            pool_valid_q <= 1'b0;
            complete_q   <= 1'b0;
            ovf_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_zero_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_count_q   <= wr_count_d;
            pool_valid_q <= pool_valid;
            complete_q   <= complete_d;
            ovf_q        <= ovf_d;
            rd_valid_q   <= rd_valid_d;
            rd_zero_q    <= rd_zero_d;
        end
    end

    layer_4_ram #(
        .DATA_W(DATA_W),
        .DEPTH (NUM_PIX),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .waddr(wr_count_q),
        .wdata(wr_data),
        .re   (rd_en & rd_in_range),
        .raddr(rd_addr),
        .rdata(ram_rdata)
    );

    assign rd_data                = rd_zero_q ? '0 : ram_rdata;
    assign rd_valid               = rd_valid_q;
    assign layer_4_ready          = (state_q == FULL);
    assign layer_4_write_complete = complete_q;
    assign overflow_err           = ovf_q;
    assign wr_count               = wr_count_q;

endmodule

// File: tb/tb_layer_4_pool_buffer.sv
// Scoreboard bench for layer_4_pool_buffer with a behavioural map model.
module tb_layer_4_pool_buffer;

    localparam int NP = 144;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       layer_4_begin = 1'b0;
    logic [7:0] pool_d_in = 8'd0;
    logic       pool_valid = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_addr = 8'd0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       layer_4_ready;
    logic       layer_4_write_complete;
    logic       overflow_err;
    logic [7:0] wr_count;

    layer_4_pool_buffer dut (
        .clk                   (clk),
        .rst                   (rst),
        .layer_4_begin         (layer_4_begin),
        .pool_d_in             (pool_d_in),
        .pool_valid            (pool_valid),
        .rd_en                 (rd_en),
        .rd_addr               (rd_addr),
        .rd_data               (rd_data),
        .rd_valid              (rd_valid),
        .layer_4_ready         (layer_4_ready),
        .layer_4_write_complete(layer_4_write_complete),
        .overflow_err          (overflow_err),
        .wr_count              (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         valid;
        bit         chk_data;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    sb[$];
    rd_exp_t    e;
    int         total = 0;
    int         bad = 0;
    int         comp_seen = 0;
    int         comp_exp = 0;

    // reference model of the map
    logic [7:0] model [NP];
    bit         known [NP];
    bit         active = 0;
    int         cnt = 0;
    bit         ovf = 0;

    bit         rd_fire = 0;
    bit         last_known = 0;
    logic [7:0] last_data = 8'd0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] clamp(input logic [7:0] d);
        return ($signed(d) < 0) ? 8'd0 : d;
    endfunction

    // monitor: read responses and completion pulses
    always @(posedge clk) rd_fire <= rd_en;

    always @(negedge clk) begin
        if (layer_4_write_complete) comp_seen++;
        if (rd_fire) begin
            if (sb.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rd_valid", int'(rd_valid), int'(e.valid));
                if (e.chk_data) begin
                    chk("rd_data", int'(rd_data), int'(e.data));
                    last_known = 1;
                    last_data  = e.data;
                end else begin
                    last_known = 0;
                end
            end
        end else if (!rst) begin
            chk("rd_valid_idle", int'(rd_valid), 0);
            if (last_known) chk("rd_hold", int'(rd_data), int'(last_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        active = 0; cnt = 0; ovf = 0;
        for (int i = 0; i < NP; i++) known[i] = 0;
        last_known = 1;
        last_data  = 8'd0;
    endtask

    task automatic do_begin();
        layer_4_begin = 1'b1;
        tick();
        layer_4_begin = 1'b0;
        active = 1; cnt = 0; ovf = 0;
    endtask

    task automatic pulse(input logic [7:0] d, input int hold, input int low);
        pool_valid = 1'b1;
        pool_d_in  = d;
        repeat (hold) tick();
        pool_valid = 1'b0;
        repeat (low) tick();
        if (active && cnt < NP) begin
            model[cnt] = clamp(d);
            known[cnt] = 1;
            cnt++;
            if (cnt == NP) comp_exp++;
        end else if (active) begin
            ovf = 1;
        end
    endtask

    task automatic rd(input int a);
        rd_exp_t x;
        x.valid    = active && (cnt == NP) && (a < NP);
        x.chk_data = (a >= NP) ? 1'b1 : known[a];
        x.data     = (a < NP) ? model[a] : 8'd0;
        sb.push_back(x);
        rd_en   = 1'b1;
        rd_addr = 8'(a);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic status(input string tag);
        chk({tag, " wr_count"}, int'(wr_count), cnt);
        chk({tag, " ready"}, int'(layer_4_ready), int'(active && cnt == NP));
        chk({tag, " overflow"}, int'(overflow_err), int'(ovf));
        chk({tag, " complete_cnt"}, comp_seen, comp_exp);
    endtask

    initial begin
        // reset and idle: captures without arming are ignored
        do_reset(3);
        chk("reset rd_data", int'(rd_data), 0);
        chk("reset rd_valid", int'(rd_valid), 0);
        chk("reset complete", int'(layer_4_write_complete), 0);
        status("reset");
        for (int i = 0; i < 3; i++) pulse(8'($urandom), 1, 3);
        status("idle");

        // full fill with i-72 on a 4-cycle cadence
        do_begin();
        status("armed");
        for (int i = 0; i < NP; i++) begin
            pulse(8'(i - 72), 1, 3);
            if (i == NP - 2) status("fill143");
        end
        status("full");
        for (int a = 0; a < NP; a++) rd(a);
        rd(150);
        rd(255);

        // overflow in FULL leaves buffer untouched
        pulse(8'h7F, 1, 3);
        status("overflow");
        rd(0); rd(100); rd(143);

        // re-arm clears overflow; reads in FILL are unqualified
        do_begin();
        status("rearm");
        rd(5);

        // held valid captures once
        pulse(8'h33, 5, 2);
        status("held");
        rd(cnt - 1);

        // mid-fill restart then complete random refill
        while (cnt < 50) pulse(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
        status("fill50");
        do_begin();
        status("restart");
        for (int i = 0; i < NP; i++)
            pulse(8'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
        status("refill");
        for (int i = 0; i < 30; i++) rd($urandom_range(0, 170));
        rd(5);

        // reset mid-fill aborts without completion
        do_begin();
        for (int i = 0; i < 20; i++) pulse(8'($urandom), 1, 1);
        status("fill20");
        do_reset(1);
        status("midreset");
        pulse(8'h11, 1, 2);
        status("postreset");
        rd(5);

        repeat (4) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
